segre_icache: RTL

- Direct-mapped, read-only instruction cache in the fetch stage of the segre pipeline.
- Serves the IF stage's fetch address and produces the hit signal that the pipeline controller uses to block IF and inject NOPs into ID.
- On a miss it fetches a whole line from the memory interface through a request/acknowledge handshake, refills the line, then resumes hitting.

---
 rtl/segre_icache.sv | 113 +++++++++++
 1 files changed

// File: rtl/segre_icache.sv
// segre_icache: direct-mapped read-only instruction cache for the IF stage.
// Same-cycle lookup; misses refill a whole line over a req/ack handshake.
module segre_icache #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int NUM_LINES = 4
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 rd_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic                 invalidate_i,
  output logic                 hit_o,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic                 mem_req_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_SIZE-1:0] mem_data_i
);

  localparam int OFF  = $clog2(LINE_SIZE / 8);
  localparam int IDX  = $clog2(NUM_LINES);
  localparam int TAG  = ADDR_SIZE - OFF - IDX;
  localparam int WPL  = LINE_SIZE / WORD_SIZE;
  localparam int WSEL = (WPL > 1) ? $clog2(WPL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    REFILL
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_SIZE-1:0] miss_addr_q, miss_addr_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG-1:0] tag_q [NUM_LINES];
  logic [WPL-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];

  logic [IDX-1:0]  idx;
  logic [TAG-1:0]  tag;
  logic [WSEL-1:0] wsel;
  logic [IDX-1:0]  widx;
  logic [TAG-1:0]  wtag;
  logic            lookup_hit;
  logic            refill_we;
  logic            unused_bits;

  assign idx  = addr_i[OFF +: IDX];
  assign tag  = addr_i[ADDR_SIZE-1 -: TAG];
  assign wsel = addr_i[2 +: WSEL];
  assign widx = miss_addr_q[OFF +: IDX];
  assign wtag = miss_addr_q[ADDR_SIZE-1 -: TAG];
  assign unused_bits = ^addr_i[1:0];

  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign refill_we  = rsn_i && (state_q == MISS) && mem_ack_i;

  assign hit_o      = rsn_i && rd_i && (state_q == IDLE) && lookup_hit;
  assign instr_o    = hit_o ? data_q[idx][wsel] : '0;
  assign mem_req_o  = rsn_i && (state_q == MISS);
  assign mem_addr_o = miss_addr_q;

  // State and latched miss address
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Valid bits; invalidate beats a coincident refill
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
    end else if (invalidate_i) begin
      valid_q <= '0;
    end else if (refill_we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Tag and data arrays, written only by a refill
  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= mem_data_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (rd_i && !lookup_hit) begin
          state_d     = MISS;
          miss_addr_d = {addr_i[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
        end
      end
      MISS: begin
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
